// File: rtl/lsu_store_buffer_pkg.sv
// Shared definitions for the LSU store buffer: request opcodes, byte-enable
// constants, default geometry and opcode classification helpers.
package lsu_store_buffer_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned AW_DEFAULT    = 11;

  function automatic logic op_is_store(op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic op_misaligned(op_e op, logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (op)
      OP_LW, OP_SW:         mis = (off != 2'b00);
      OP_LH, OP_LHU, OP_SH: mis = off[0];
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_store_buffer_align.sv
// Combinational lane steering: store byte enables / replicated write data,
// and load byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_store_buffer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wd,
  input  logic [31:0] rd_data,
  output logic [31:0] ld_data
);

  op_e         op_t;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign op_t     = op_e'(op);
  assign half_sel = off[1] ? rd_data[31:16] : rd_data[15:0];

  always_comb begin
    st_be = BE_NONE;
    st_wd = st_data;
    case (op_t)
      OP_SW: st_be = BE_WORD;
      OP_SH: begin
        st_be = off[1] ? BE_HALF_HI : BE_HALF_LO;
        st_wd = {2{st_data[15:0]}};
      end
      OP_SB: begin
        st_be = BE_BYTE0 << off;
        st_wd = {4{st_data[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = rd_data[7:0];
    case (off)
      2'd1:    byte_sel = rd_data[15:8];
      2'd2:    byte_sel = rd_data[23:16];
      2'd3:    byte_sel = rd_data[31:24];
      default: byte_sel = rd_data[7:0];
    endcase
  end

  always_comb begin
    ld_data = rd_data;
    case (op_t)
      OP_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ld_data = {16'h0000, half_sel};
      OP_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ld_data = {24'h000000, byte_sel};
      default: ld_data = rd_data;
    endcase
  end

endmodule

// File: rtl/lsu_store_buffer.sv
// Load/store front end: aligned stores queue in a small FIFO that drains when
// the memory port is idle; loads bypass the queue unless a word hazard exists.
module lsu_store_buffer
  import lsu_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Req_Valid,
  output logic          Req_Ready,
  input  logic [2:0]    Req_Op,
  input  logic [31:0]   Req_Addr,
  input  logic [31:0]   Req_WData,
  output logic          Ld_Valid,
  output logic [31:0]   Ld_Data,
  output logic          Exc_AdEL,
  output logic          Exc_AdES,
  output logic          Buf_Empty,
  output logic          DM_We,
  output logic [AW-1:0] DM_A,
  output logic [3:0]    DM_BE,
  output logic [31:0]   DM_WD,
  input  logic [31:0]   DM_RD
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [AW-1:0]    ent_a  [DEPTH];
  logic [3:0]       ent_be [DEPTH];
  logic [31:0]      ent_wd [DEPTH];
  logic [DEPTH-1:0] ent_v;
  logic [PW-1:0]    head, tail;
  logic [PW:0]      count;

  op_e           op;
  logic [1:0]    off;
  logic [AW-1:0] req_wa;
  logic          is_st, mis, hazard, load_acc, drain, push;
  logic [3:0]    al_be;
  logic [31:0]   al_wd, al_ld;
  logic          unused_addr;

  assign op          = op_e'(Req_Op);
  assign off         = Req_Addr[1:0];
  assign req_wa      = Req_Addr[AW+1:2];
  assign is_st       = op_is_store(op);
  assign mis         = op_misaligned(op, off);
  assign unused_addr = ^Req_Addr[31:AW+2];

  lsu_align u_align (
    .op      (Req_Op),
    .off     (off),
    .st_data (Req_WData),
    .st_be   (al_be),
    .st_wd   (al_wd),
    .rd_data (DM_RD),
    .ld_data (al_ld)
  );

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_v[i] && (ent_a[i] == req_wa)) hazard = 1'b1;
    end
  end

  assign load_acc  = Req_Valid && !is_st && !mis && !hazard;
  assign drain     = (count != '0) && !load_acc;
  assign push      = Req_Valid && is_st && !mis && ((count != FULL) || drain);
  assign Buf_Empty = (count == '0);

  always_comb begin
    Req_Ready = 1'b1;
    if (mis)         Req_Ready = 1'b1;
    else if (!is_st) Req_Ready = !hazard;
    else             Req_Ready = (count != FULL) || drain;
  end

  always_comb begin
    DM_We = 1'b0;
    DM_A  = '0;
    DM_BE = BE_NONE;
    DM_WD = '0;
    if (load_acc) begin
      DM_A = req_wa;
    end else if (drain) begin
      DM_We = 1'b1;
      DM_A  = ent_a[head];
      DM_BE = ent_be[head];
      DM_WD = ent_wd[head];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ent_v    <= '0;
      Ld_Valid <= 1'b0;
      Ld_Data  <= '0;
      Exc_AdEL <= 1'b0;
      Exc_AdES <= 1'b0;
    end else begin
      // On a full-buffer push+drain head==tail; the push's set must win.
      if (drain) begin
        head        <= head + PW'(1);
        ent_v[head] <= 1'b0;
      end
      if (push) begin
        tail        <= tail + PW'(1);
        ent_v[tail] <= 1'b1;
      end
      case ({push, drain})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      Ld_Valid <= load_acc;
      if (load_acc) Ld_Data <= al_ld;
      Exc_AdEL <= Req_Valid && mis && !is_st;
      Exc_AdES <= Req_Valid && mis && is_st;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      ent_a[tail]  <= req_wa;
      ent_be[tail] <= al_be;
      ent_wd[tail] <= al_wd;
    end
  end

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Bench for lsu_store_buffer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_lsu_store_buffer;

  localparam int DEPTH = 4;
  localparam logic [2:0] T_LW = 3'd0, T_LH = 3'd1, T_LHU = 3'd2, T_LB = 3'd3,
                         T_LBU = 3'd4, T_SW = 3'd5, T_SH = 3'd6, T_SB = 3'd7;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Req_Valid = 1'b0;
  logic        Req_Ready;
  logic [2:0]  Req_Op = 3'd0;
  logic [31:0] Req_Addr = 32'h0;
  logic [31:0] Req_WData = 32'h0;
  logic        Ld_Valid;
  logic [31:0] Ld_Data;
  logic        Exc_AdEL, Exc_AdES, Buf_Empty, DM_We;
  logic [10:0] DM_A;
  logic [3:0]  DM_BE;
  logic [31:0] DM_WD, DM_RD;

  lsu_store_buffer #(.DEPTH(DEPTH), .AW(11)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Req_Op(Req_Op), .Req_Addr(Req_Addr), .Req_WData(Req_WData),
    .Ld_Valid(Ld_Valid), .Ld_Data(Ld_Data), .Exc_AdEL(Exc_AdEL), .Exc_AdES(Exc_AdES),
    .Buf_Empty(Buf_Empty), .DM_We(DM_We), .DM_A(DM_A), .DM_BE(DM_BE),
    .DM_WD(DM_WD), .DM_RD(DM_RD)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] seed_word(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Data memory seen by the DUT
  logic [31:0] mem [2048];
  logic        mem_ready = 1'b0;
  assign DM_RD = mem[DM_A];

  always @(posedge Clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2048; i++) mem[i] <= seed_word(i);
      mem_ready <= 1'b1;
    end else if (DM_We) begin
      for (int b = 0; b < 4; b++)
        if (DM_BE[b]) mem[DM_A][8*b +: 8] <= DM_WD[8*b +: 8];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [10:0] wa;
    logic [3:0]  be;
    logic [31:0] wd;
  } st_t;

  st_t         sbq[$];
  logic [31:0] refmem [2048];
  bit          ref_init = 1'b0;
  bit          exp_lv = 1'b0, exp_el = 1'b0, exp_es = 1'b0;
  logic [31:0] exp_ld = 32'h0;

  function automatic bit m_mis(logic [2:0] op, logic [1:0] off);
    if (op == T_LW || op == T_SW) return off != 2'd0;
    if (op == T_LH || op == T_LHU || op == T_SH) return off[0];
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] op, logic [1:0] off);
    int o = int'(off);
    if (op == T_SW) return 4'hF;
    if (op == T_SH) return (o >= 2) ? 4'hC : 4'h3;
    return 4'((1 << o) & 15);
  endfunction

  function automatic logic [31:0] m_wd(logic [2:0] op, logic [31:0] d);
    if (op == T_SW) return d;
    if (op == T_SH) return (d & 32'hFFFF) * 32'h0001_0001;
    return (d & 32'hFF) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] op, logic [1:0] off, logic [31:0] w);
    int o = int'(off);
    logic [31:0] b = (w >> (8 * o)) & 32'hFF;
    logic [31:0] h = (w >> (16 * (o / 2))) & 32'hFFFF;
    case (op)
      T_LB:    return b[7] ? (b | 32'hFFFF_FF00) : b;
      T_LBU:   return b;
      T_LH:    return h[15] ? (h | 32'hFFFF_0000) : h;
      T_LHU:   return h;
      default: return w;
    endcase
  endfunction

  always @(negedge Clk) begin : cmp
    logic [2:0]  op;
    logic [1:0]  off;
    logic [10:0] wa;
    bit          st, mis, hz, rdy, acc, ld_go;
    st_t         e;
    if (!ref_init) begin
      for (int i = 0; i < 2048; i++) refmem[i] = seed_word(i);
      ref_init = 1'b1;
    end
    if (!Reset_n) begin
      sbq.delete();
      exp_lv = 1'b0; exp_el = 1'b0; exp_es = 1'b0; exp_ld = 32'h0;
      chk("rst_dm_we", 32'(DM_We), 32'd0);
      chk("rst_buf_empty", 32'(Buf_Empty), 32'd1);
      chk("rst_ld_valid", 32'(Ld_Valid), 32'd0);
      chk("rst_ld_data", Ld_Data, 32'd0);
    end else begin
      chk("ld_valid", 32'(Ld_Valid), 32'(exp_lv));
      if (exp_lv) chk("ld_data", Ld_Data, exp_ld);
      chk("exc_adel", 32'(Exc_AdEL), 32'(exp_el));
      chk("exc_ades", 32'(Exc_AdES), 32'(exp_es));
      chk("buf_empty", 32'(Buf_Empty), 32'(sbq.size() == 0));

      op  = Req_Op;
      off = Req_Addr[1:0];
      wa  = Req_Addr[12:2];
      st  = (op >= T_SW);
      mis = m_mis(op, off);
      hz  = 1'b0;
      foreach (sbq[i]) if (sbq[i].wa == wa) hz = 1'b1;
      ld_go = Req_Valid && !st && !mis && !hz;
      if (mis)      rdy = 1'b1;
      else if (!st) rdy = !hz;
      else          rdy = (sbq.size() < DEPTH) || (sbq.size() > 0 && !ld_go);
      if (Req_Valid) chk("req_ready", 32'(Req_Ready), 32'(rdy));
      acc = Req_Valid && rdy;

      if (ld_go) begin
        chk("load_dm_we", 32'(DM_We), 32'd0);
        chk("load_dm_a", 32'(DM_A), 32'(wa));
        exp_ld = m_load(op, off, refmem[wa]);
      end else if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("drain_dm_we", 32'(DM_We), 32'd1);
        chk("drain_dm_a", 32'(DM_A), 32'(e.wa));
        chk("drain_dm_be", 32'(DM_BE), 32'(e.be));
        chk("drain_dm_wd", DM_WD, e.wd);
        for (int b = 0; b < 4; b++)
          if (e.be[b]) refmem[e.wa][8*b +: 8] = e.wd[8*b +: 8];
      end else begin
        chk("idle_dm_we", 32'(DM_We), 32'd0);
        chk("idle_dm_be", 32'(DM_BE), 32'd0);
      end

      if (acc && st && !mis) sbq.push_back('{wa, m_be(op, off), m_wd(op, Req_WData)});
      exp_lv = ld_go;
      exp_el = acc && !st && mis;
      exp_es = acc && st && mis;
    end
  end

  // ---------------- stimulus ----------------
  // Entry and exit points of these tasks are 1 ns after a rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] data, output int waited);
    Req_Valid = 1'b1; Req_Op = op; Req_Addr = addr; Req_WData = data;
    waited = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge Clk); #1;
      if (Req_Ready) break;
      waited++;
      @(posedge Clk); #1;
    end
    if (waited >= 40) chk("accept_timeout", 32'(waited), 32'd0);
    @(posedge Clk); #1;
    Req_Valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    for (n = 0; n < 40; n++) begin
      @(negedge Clk); #1;
      if (Buf_Empty) break;
      @(posedge Clk); #1;
    end
    if (n >= 40) chk("empty_timeout", 32'(n), 32'd0);
    else begin
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    int w;
    int bad;
    logic [31:0] keep;

    repeat (3) @(posedge Clk);
    @(negedge Clk); #1;
    chk("reset_buf_empty", 32'(Buf_Empty), 32'd1);
    chk("reset_ld_data", Ld_Data, 32'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    // SB lane replication and byte-extended reload
    issue(T_SB, 32'h103, 32'h0000_00AB, w);
    @(negedge Clk); #1;
    chk("sb_dm_we", 32'(DM_We), 32'd1);
    chk("sb_dm_a", 32'(DM_A), 32'h40);
    chk("sb_dm_be", 32'(DM_BE), 32'b1000);
    chk("sb_dm_wd", DM_WD, 32'hABAB_ABAB);
    @(posedge Clk); #1;
    wait_empty();
    issue(T_LBU, 32'h103, 32'h0, w);
    @(negedge Clk); #1;
    chk("lbu_data", Ld_Data, 32'h0000_00AB);
    @(posedge Clk); #1;
    issue(T_LB, 32'h103, 32'h0, w);
    @(negedge Clk); #1;
    chk("lb_data", Ld_Data, 32'hFFFF_FFAB);
    @(posedge Clk); #1;

    // Load behind a store to the same word stalls for one drain
    issue(T_SH, 32'h22, 32'h0000_1234, w);
    Req_Valid = 1'b1; Req_Op = T_LH; Req_Addr = 32'h22;
    @(negedge Clk); #1;
    chk("haz_ready", 32'(Req_Ready), 32'd0);
    chk("haz_dm_be", 32'(DM_BE), 32'b1100);
    chk("haz_dm_a", 32'(DM_A), 32'h8);
    @(posedge Clk); #1;
    issue(T_LH, 32'h22, 32'h0, w);
    chk("haz_wait", 32'(w), 32'd0);
    @(negedge Clk); #1;
    chk("haz_ld_valid", 32'(Ld_Valid), 32'd1);
    chk("haz_ld_data", Ld_Data, 32'h0000_1234);
    @(posedge Clk); #1;

    // Back-to-back stores each take the port the cycle after they arrive
    for (int i = 0; i < 5; i++) begin
      issue(T_SW, 32'h200 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), w);
      chk("sw_first_cycle", 32'(w), 32'd0);
    end
    repeat (4) @(posedge Clk);
    #1;
    chk("sw_drained_empty", 32'(Buf_Empty), 32'd1);

    // Unrelated load bypasses a pending store
    issue(T_SW, 32'h10, 32'h1111_2222, w);
    Req_Valid = 1'b1; Req_Op = T_LW; Req_Addr = 32'h80;
    @(negedge Clk); #1;
    chk("bypass_ready", 32'(Req_Ready), 32'd1);
    chk("bypass_dm_we", 32'(DM_We), 32'd0);
    chk("bypass_pending", 32'(Buf_Empty), 32'd0);
    @(posedge Clk); #1;
    Req_Valid = 1'b0;
    @(negedge Clk); #1;
    chk("bypass_ld_valid", 32'(Ld_Valid), 32'd1);
    chk("bypass_ld_data", Ld_Data, seed_word(32'h20));
    @(posedge Clk); #1;
    wait_empty();

    // Misaligned accesses
    Req_Valid = 1'b1; Req_Op = T_LW; Req_Addr = 32'h02;
    @(negedge Clk); #1;
    chk("adel_ready", 32'(Req_Ready), 32'd1);
    chk("adel_no_access", 32'(DM_We), 32'd0);
    @(posedge Clk); #1;
    Req_Valid = 1'b0;
    @(negedge Clk); #1;
    chk("adel_pulse", 32'(Exc_AdEL), 32'd1);
    @(posedge Clk); #1;
    issue(T_SH, 32'h05, 32'hFFFF, w);
    @(negedge Clk); #1;
    chk("ades_pulse", 32'(Exc_AdES), 32'd1);
    chk("ades_no_push", 32'(Buf_Empty), 32'd1);
    @(posedge Clk); #1;

    // Reset discards a buffered store before it reaches memory
    keep = mem[11'hC0];
    issue(T_SW, 32'h300, 32'hDEAD_BEEF, w);
    Reset_n = 1'b0;
    #1;
    chk("rstmid_dm_we", 32'(DM_We), 32'd0);
    chk("rstmid_empty", 32'(Buf_Empty), 32'd1);
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("rstmid_mem_kept", mem[11'hC0], keep);

    // Randomized traffic over a small window of words to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      Reset_n   = ($urandom_range(0, 499) != 0);
      Req_Valid = ($urandom_range(0, 3) != 0);
      Req_Op    = 3'($urandom_range(0, 7));
      Req_Addr  = (32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)))
                  | ($urandom & 32'hFFFF_E000);
      Req_WData = $urandom;
      @(posedge Clk); #1;
    end
    Reset_n = 1'b1;
    Req_Valid = 1'b0;
    repeat (10) @(posedge Clk);
    #1;

    bad = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== refmem[i]) bad++;
    chk("final_memory_words_differing", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
